// File: rtl/mem_arb.sv
// mem_arb: single-port memory sequencer shared by fetch and load/store; IDLE->BUSY->RESP, vld at grant+MEM_LAT+1.
// Requesters hold req until their vld pulse; fetch hold tracks i_fet_req. Optional MEM_ARB_PERF_EN adds stall/wait counters.
module mem_arb #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fet_req,
   input  logic [31:0] i_fet_addr,
   input  logic        i_fet_kill,
   output logic [31:0] o_fet_rdata,
   output logic        o_fet_vld,
   output logic        o_fet_hold,
   input  logic        i_dat_req,
   input  logic        i_dat_wen,
   input  logic [31:0] i_dat_addr,
   input  logic [31:0] i_dat_wdata,
   input  logic [3:0]  i_dat_mask,
   output logic [31:0] o_dat_rdata,
   output logic        o_dat_vld,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_fet_stall_cnt,
   output logic [31:0] o_dat_wait_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic        own_fet_q, own_fet_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  mask_q, mask_d;
   logic [2:0]  lat_q, lat_d;
   logic [3:0]  starve_q, starve_d;
   logic        kill_q, kill_d;
   logic [31:0] fet_rdata_q, fet_rdata_d;
   logic [31:0] dat_rdata_q, dat_rdata_d;
   logic        grant_fet, grant_dat;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         own_fet_q   <= 1'b0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         lat_q       <= '0;
         starve_q    <= '0;
         kill_q      <= 1'b0;
         fet_rdata_q <= '0;
         dat_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         own_fet_q   <= own_fet_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         kill_q      <= kill_d;
         fet_rdata_q <= fet_rdata_d;
         dat_rdata_q <= dat_rdata_d;
      end
   end

   // A killed fetch may not be granted; data yields only when fetch has starved long enough.
   assign grant_fet = (state_q == S_IDLE) & i_fet_req & ~i_fet_kill &
                      (~i_dat_req | (starve_q == STARVE_LIM));
   assign grant_dat = (state_q == S_IDLE) & i_dat_req & ~grant_fet;

   always_comb begin
      state_d     = state_q;
      own_fet_d   = own_fet_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      kill_d      = kill_q;
      fet_rdata_d = fet_rdata_q;
      dat_rdata_d = dat_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            kill_d = 1'b0;
            if (grant_fet | grant_dat) begin
               own_fet_d = grant_fet;
               addr_d    = grant_fet ? i_fet_addr : i_dat_addr;
               wen_d     = grant_dat & i_dat_wen;
               wdata_d   = grant_dat ? i_dat_wdata : 32'h0;
               mask_d    = grant_dat ? i_dat_mask : 4'h0;
               lat_d     = LAT_INIT;
               state_d   = S_BUSY;
            end
         end
         S_BUSY: begin
            if (own_fet_q & i_fet_kill) kill_d = 1'b1;
            if (lat_q == 3'd0) begin
               if (own_fet_q) fet_rdata_d = wen_q ? 32'h0 : i_mem_rdata;
               else           dat_rdata_d = wen_q ? 32'h0 : i_mem_rdata;
               state_d = S_RESP;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         S_RESP: begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (~i_fet_req)
         starve_d = 4'd0;
      else if (grant_fet)
         starve_d = 4'd0;
      else if (grant_dat & ~i_fet_kill & (starve_q != STARVE_LIM))
         starve_d = starve_q + 4'd1;
   end

   always_comb begin
      o_mem_addr  = 32'h0;
      o_mem_ren   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_wdata = 32'h0;
      o_mem_mask  = 4'h0;
      o_fet_vld   = 1'b0;
      o_dat_vld   = 1'b0;
      unique case (state_q)
         S_BUSY: begin
            o_mem_addr  = addr_q;
            o_mem_ren   = ~wen_q;
            o_mem_wen   = wen_q;
            o_mem_wdata = wdata_q;
            o_mem_mask  = mask_q;
         end
         S_RESP: begin
            // a kill arriving in the response cycle itself also swallows the pulse
            o_fet_vld = own_fet_q & ~kill_q & ~i_fet_kill;
            o_dat_vld = ~own_fet_q;
         end
         default: ;
      endcase
   end

   assign o_fet_hold  = i_fet_req & ~o_fet_vld;
   assign o_fet_rdata = fet_rdata_q;
   assign o_dat_rdata = dat_rdata_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] fet_stall_cnt_q, fet_stall_cnt_d;
   logic [31:0] dat_wait_cnt_q, dat_wait_cnt_d;

   always_comb begin
      fet_stall_cnt_d = fet_stall_cnt_q + (o_fet_hold ? 32'd1 : 32'd0);
      dat_wait_cnt_d  = dat_wait_cnt_q + ((i_dat_req & ~o_dat_vld) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fet_stall_cnt_q <= '0;
         dat_wait_cnt_q  <= '0;
      end else begin
         fet_stall_cnt_q <= fet_stall_cnt_d;
         dat_wait_cnt_q  <= dat_wait_cnt_d;
      end
   end

   assign o_fet_stall_cnt = fet_stall_cnt_q;
   assign o_dat_wait_cnt  = dat_wait_cnt_q;
`else
   assign o_fet_stall_cnt = 32'h0;
   assign o_dat_wait_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (MEM_LAT=2, STARVE_MAX=2) with completion and memory-bus scoreboards.
module tb_mem_arb;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_fet_req, i_fet_kill, i_dat_req, i_dat_wen;
   logic [31:0] i_fet_addr, i_dat_addr, i_dat_wdata, i_mem_rdata;
   logic [3:0]  i_dat_mask;
   logic [31:0] o_fet_rdata, o_dat_rdata, o_mem_addr, o_mem_wdata;
   logic [31:0] o_fet_stall_cnt, o_dat_wait_cnt;
   logic        o_fet_vld, o_fet_hold, o_dat_vld, o_mem_ren, o_mem_wen;
   logic [3:0]  o_mem_mask;

   mem_arb #(.MEM_LAT(LAT), .STARVE_MAX(2)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_fet_req(i_fet_req), .i_fet_addr(i_fet_addr), .i_fet_kill(i_fet_kill),
      .o_fet_rdata(o_fet_rdata), .o_fet_vld(o_fet_vld), .o_fet_hold(o_fet_hold),
      .i_dat_req(i_dat_req), .i_dat_wen(i_dat_wen), .i_dat_addr(i_dat_addr),
      .i_dat_wdata(i_dat_wdata), .i_dat_mask(i_dat_mask),
      .o_dat_rdata(o_dat_rdata), .o_dat_vld(o_dat_vld),
      .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
      .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask), .i_mem_rdata(i_mem_rdata),
      .o_fet_stall_cnt(o_fet_stall_cnt), .o_dat_wait_cnt(o_dat_wait_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic fet; logic [31:0] rdata; int cyc; } cmp_t;
   typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; } acc_t;

   cmp_t cmp_q[$];
   acc_t acc_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   run   = 0;
   logic mon_en = 1'b1;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h100) ? 32'h33 : {a[15:0], ~a[15:0]};
   endfunction

   assign i_mem_rdata = o_mem_ren ? memf(o_mem_addr) : 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic push_cmp(input logic fet, input logic [31:0] rd, input int c);
      cmp_t e;
      e.fet = fet; e.rdata = rd; e.cyc = c;
      cmp_q.push_back(e);
   endtask

   task automatic push_acc(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m);
      acc_t e;
      e.wen = wen; e.addr = a; e.wdata = wd; e.mask = m;
      acc_q.push_back(e);
   endtask

   // Completion scoreboard: every vld pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (o_fet_vld || o_dat_vld) begin
         chk("vld_exclusive", {31'h0, o_fet_vld & o_dat_vld}, 32'h0);
         if (cmp_q.size() == 0) begin
            chk("unexpected_vld", 32'h1, 32'h0);
         end else begin
            cmp_t e;
            e = cmp_q.pop_front();
            chk("vld_owner", {31'h0, o_fet_vld}, {31'h0, e.fet});
            chk("vld_cycle", cyc, e.cyc);
            chk("vld_rdata", e.fet ? o_fet_rdata : o_dat_rdata, e.rdata);
         end
      end
   end

   // Memory-bus scoreboard: each access must hold its values for exactly LAT cycles.
   always @(negedge clk) begin
      if (!mon_en) begin
         run = 0;
      end else if (o_mem_ren || o_mem_wen) begin
         if (acc_q.size() == 0) begin
            chk("unexpected_mem_access", 32'h1, 32'h0);
         end else begin
            chk("mem_wen", {31'h0, o_mem_wen}, {31'h0, acc_q[0].wen});
            chk("mem_ren", {31'h0, o_mem_ren}, {31'h0, ~acc_q[0].wen});
            chk("mem_addr", o_mem_addr, acc_q[0].addr);
            if (acc_q[0].wen) begin
               chk("mem_wdata", o_mem_wdata, acc_q[0].wdata);
               chk("mem_mask", {28'h0, o_mem_mask}, {28'h0, acc_q[0].mask});
            end
         end
         run++;
      end else if (run > 0) begin
         chk("mem_run_len", run, LAT);
         if (acc_q.size() > 0) void'(acc_q.pop_front());
         run = 0;
      end
   end

   initial begin
      int t;
      i_rst = 1'b1;
      i_fet_req = 1'b0; i_fet_kill = 1'b0; i_fet_addr = '0;
      i_dat_req = 1'b0; i_dat_wen = 1'b0; i_dat_addr = '0; i_dat_wdata = '0; i_dat_mask = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_mem_ren", {31'h0, o_mem_ren}, 32'h0);
      chk("rst_mem_wen", {31'h0, o_mem_wen}, 32'h0);
      chk("rst_mem_addr", o_mem_addr, 32'h0);
      chk("rst_fet_vld", {31'h0, o_fet_vld}, 32'h0);
      chk("rst_dat_vld", {31'h0, o_dat_vld}, 32'h0);
      chk("rst_fet_rdata", o_fet_rdata, 32'h0);
      chk("rst_dat_rdata", o_dat_rdata, 32'h0);
      tick();
      i_rst = 1'b0;
      tick();

      // Fetch alone: vld at t+3, hold high t..t+2 and low in the vld cycle
      t = cyc;
      i_fet_req = 1'b1; i_fet_addr = 32'h100;
      push_acc(1'b0, 32'h100, 32'h0, 4'h0);
      push_cmp(1'b1, 32'h33, t + 3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("fet_hold", {31'h0, o_fet_hold}, (k == 3) ? 32'h0 : 32'h1);
         if (k < 3) tick();
      end
      go_to(t + 4);
      i_fet_req = 1'b0;
      go_to(t + 6);

      // Simultaneous fetch and data read: data first, fetch granted at t+4
      t = cyc;
      i_fet_req = 1'b1; i_fet_addr = 32'h104;
      i_dat_req = 1'b1; i_dat_addr = 32'h2000;
      push_acc(1'b0, 32'h2000, 32'h0, 4'h0);
      push_acc(1'b0, 32'h104, 32'h0, 4'h0);
      push_cmp(1'b0, memf(32'h2000), t + 3);
      push_cmp(1'b1, memf(32'h104), t + 7);
      go_to(t + 4);
      i_dat_req = 1'b0;
      go_to(t + 8);
      i_fet_req = 1'b0;
      chk("fet_rdata_hold", o_fet_rdata, memf(32'h104));
      go_to(t + 10);

      // Data write: write enable for LAT cycles, completion returns zero data
      t = cyc;
      i_dat_req = 1'b1; i_dat_wen = 1'b1; i_dat_addr = 32'h2004;
      i_dat_wdata = 32'hDEADBEEF; i_dat_mask = 4'h3;
      push_acc(1'b1, 32'h2004, 32'hDEADBEEF, 4'h3);
      push_cmp(1'b0, 32'h0, t + 3);
      go_to(t + 4);
      i_dat_req = 1'b0; i_dat_wen = 1'b0; i_dat_wdata = '0; i_dat_mask = '0;
      go_to(t + 6);

      // Starvation: data, data, fetch, data
      t = cyc;
      i_fet_req = 1'b1; i_fet_addr = 32'h108;
      i_dat_req = 1'b1; i_dat_addr = 32'h3000;
      push_acc(1'b0, 32'h3000, 32'h0, 4'h0);
      push_acc(1'b0, 32'h3004, 32'h0, 4'h0);
      push_acc(1'b0, 32'h108, 32'h0, 4'h0);
      push_acc(1'b0, 32'h3008, 32'h0, 4'h0);
      push_cmp(1'b0, memf(32'h3000), t + 3);
      push_cmp(1'b0, memf(32'h3004), t + 7);
      push_cmp(1'b1, memf(32'h108), t + 11);
      push_cmp(1'b0, memf(32'h3008), t + 15);
      go_to(t + 4);
      i_dat_addr = 32'h3004;
      go_to(t + 8);
      i_dat_addr = 32'h3008;
      go_to(t + 12);
      i_fet_req = 1'b0;
      go_to(t + 16);
      i_dat_req = 1'b0;
      go_to(t + 18);

      // Kill in IDLE blocks the fetch grant
      t = cyc;
      i_fet_req = 1'b1; i_fet_kill = 1'b1; i_fet_addr = 32'h300;
      go_to(t + 1);
      i_fet_req = 1'b0; i_fet_kill = 1'b0;
      @(negedge clk);
      chk("kill_idle_no_ren", {31'h0, o_mem_ren}, 32'h0);
      go_to(t + 3);

      // Kill in second BUSY cycle: access completes silently, redirected fetch returns
      t = cyc;
      i_fet_req = 1'b1; i_fet_addr = 32'h100;
      push_acc(1'b0, 32'h100, 32'h0, 4'h0);
      push_acc(1'b0, 32'h200, 32'h0, 4'h0);
      push_cmp(1'b1, memf(32'h200), t + 7);
      go_to(t + 2);
      i_fet_kill = 1'b1; i_fet_addr = 32'h200;
      go_to(t + 3);
      i_fet_kill = 1'b0;
      @(negedge clk);
      chk("kill_no_fet_vld", {31'h0, o_fet_vld}, 32'h0);
      chk("kill_hold", {31'h0, o_fet_hold}, 32'h1);
      go_to(t + 8);
      i_fet_req = 1'b0;
      go_to(t + 10);

      // Reset in BUSY aborts the access with no vld
      chk("queues_drained_cmp", cmp_q.size(), 32'h0);
      chk("queues_drained_acc", acc_q.size(), 32'h0);
      mon_en = 1'b0;
      t = cyc;
      i_dat_req = 1'b1; i_dat_addr = 32'h4000;
      go_to(t + 1);
      @(negedge clk);
      chk("busy_ren", {31'h0, o_mem_ren}, 32'h1);
      chk("busy_addr", o_mem_addr, 32'h4000);
      i_rst = 1'b1;
      go_to(t + 2);
      @(negedge clk);
      chk("abort_ren", {31'h0, o_mem_ren}, 32'h0);
      chk("abort_addr", o_mem_addr, 32'h0);
      chk("abort_dat_vld", {31'h0, o_dat_vld}, 32'h0);
      chk("abort_stall_cnt", o_fet_stall_cnt, 32'h0);
      chk("abort_wait_cnt", o_dat_wait_cnt, 32'h0);
      i_dat_req = 1'b0;
      go_to(t + 3);
      i_rst = 1'b0;
      go_to(t + 8);
      @(negedge clk);
      chk("abort_dat_rdata", o_dat_rdata, 32'h0);
      chk("final_cmp_empty", cmp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
